// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Flush loads the bubble value; a saturating counter tracks back-pressure cycles.
module pipe_skid_reg #(
    parameter int unsigned          DATA_W = 64,
    parameter logic [DATA_W-1:0]    BUBBLE = {DATA_W{1'b0}},
    parameter int unsigned          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StFull;
                        main_d  = in_data;
                    end
                end
                StFull: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = StSkid;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        state_d = StFull;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
        // Handshake flags are decoded from the next state so both outputs come straight from flops.
        in_ready_d  = (state_d != StSkid);
        out_valid_d = (state_d != StEmpty);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        unique case (state_q)
            StEmpty: occupancy = 2'd0;
            StFull:  occupancy = 2'd1;
            StSkid:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? main_q : BUBBLE;
    assign stall_cnt = stall_cnt_q;

endmodule
